// File: rtl/uart_tx_sched_pkg.sv
// Shared types and helpers for the round-robin UART TX scheduler.
// HDR_ID_W covers the largest supported requester count (16).
package uart_tx_sched_pkg;

    localparam int MAX_REQ  = 16;
    localparam int HDR_ID_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        SEND,
        WAIT_HI,
        WAIT_LO
    } sched_state_e;

    function automatic logic [HDR_ID_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [HDR_ID_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx |= HDR_ID_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or above rr_ptr,
// otherwise the lowest set bit overall (wrap-around).
module uart_rr_arbiter
    import uart_tx_sched_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]    req,
    input  logic [HDR_ID_W-1:0] rr_ptr,
    output logic [N_REQ-1:0]    winner,
    output logic                any
);

    localparam logic [N_REQ-1:0] LSB = {{(N_REQ-1){1'b0}}, 1'b1};

    logic [N_REQ-1:0] upper_mask;
    logic [N_REQ-1:0] upper_req;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
            assign upper_mask[gi] = (HDR_ID_W'(gi) >= rr_ptr);
        end
    endgenerate

    assign upper_req = req & upper_mask;
    // x & (~x + 1) isolates the lowest set bit
    assign winner = (|upper_req) ? (upper_req & (~upper_req + LSB))
                                 : (req & (~req + LSB));
    assign any    = |req;

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART TX among N_REQ byte streams.
// Define UART_TX_SCHED_ID_HDR_EN to prefix every grant with a requester-ID frame.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]            req_last,
    output logic [N_REQ-1:0]            req_ack,
    output logic [N_REQ-1:0]            grant,
    output logic [DATA_WIDTH-1:0]       tx_data,
    output logic                        tx_valid,
    input  logic                        tx_busy,
    output logic                        sched_busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    sched_state_e          state_reg, state_next;
    logic [N_REQ-1:0]      grant_reg, grant_next;
    logic [HDR_ID_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [CNT_W-1:0]      burst_cnt_reg, burst_cnt_next;
    logic                  last_q_reg;
    logic [DATA_WIDTH-1:0] tx_data_reg;
    logic                  tx_valid_reg, tx_valid_next;
    logic [N_REQ-1:0]      req_ack_reg;

    logic                  go_send;
    logic                  from_hdr;
    logic                  release_now;
    logic [N_REQ-1:0]      winner;
    logic                  any_req;
    logic [MAX_REQ-1:0]    grant_pad;
    logic [HDR_ID_W-1:0]   g_idx;
    logic [DATA_WIDTH-1:0] data_masked [N_REQ];
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_last;

`ifdef UART_TX_SCHED_ID_HDR_EN
    logic                  go_hdr;
    logic                  in_hdr_reg;
    logic [MAX_REQ-1:0]    grant_next_pad;
`endif

    uart_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req    (req),
        .rr_ptr (rr_ptr_reg),
        .winner (winner),
        .any    (any_req)
    );

    // Byte/last selection follows grant_next so IDLE can launch the first frame directly.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_sel
            assign data_masked[gi] = grant_next[gi] ? req_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
    endgenerate

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) sel_data |= data_masked[i];
    end

    assign sel_last = |(grant_next & req_last);

    always_comb begin
        grant_pad = '0;
        grant_pad[N_REQ-1:0] = grant_reg;
    end

    assign g_idx       = onehot_to_idx(grant_pad);
    assign release_now = last_q_reg || (burst_cnt_reg == CNT_W'(MAX_BURST)) || !(|(grant_reg & req));

`ifdef UART_TX_SCHED_ID_HDR_EN
    assign from_hdr = in_hdr_reg;
    always_comb begin
        grant_next_pad = '0;
        grant_next_pad[N_REQ-1:0] = grant_next;
    end
`else
    assign from_hdr = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        rr_ptr_next    = rr_ptr_reg;
        burst_cnt_next = burst_cnt_reg;
        go_send        = 1'b0;
`ifdef UART_TX_SCHED_ID_HDR_EN
        go_hdr         = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    grant_next     = winner;
                    burst_cnt_next = '0;
`ifdef UART_TX_SCHED_ID_HDR_EN
                    state_next     = HDR;
                    go_hdr         = 1'b1;
`else
                    state_next     = SEND;
                    go_send        = 1'b1;
`endif
                end
            end
`ifdef UART_TX_SCHED_ID_HDR_EN
            HDR:     state_next = WAIT_HI;
`endif
            SEND:    state_next = WAIT_HI;
            WAIT_HI: if (tx_busy) state_next = WAIT_LO;
            WAIT_LO: begin
                if (!tx_busy) begin
                    if (from_hdr || !release_now) begin
                        state_next = SEND;
                        go_send    = 1'b1;
                    end else begin
                        grant_next  = '0;
                        rr_ptr_next = (g_idx == HDR_ID_W'(N_REQ - 1)) ? '0 : g_idx + HDR_ID_W'(1);
                        state_next  = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (go_send) burst_cnt_next = burst_cnt_next + CNT_W'(1);
    end

`ifdef UART_TX_SCHED_ID_HDR_EN
    assign tx_valid_next = go_send | go_hdr;
`else
    assign tx_valid_next = go_send;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            rr_ptr_reg    <= '0;
            burst_cnt_reg <= '0;
            last_q_reg    <= 1'b0;
            tx_data_reg   <= '0;
            tx_valid_reg  <= 1'b0;
            req_ack_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            rr_ptr_reg    <= rr_ptr_next;
            burst_cnt_reg <= burst_cnt_next;
            tx_valid_reg  <= tx_valid_next;
            req_ack_reg   <= go_send ? grant_next : '0;
            if (go_send) begin
                tx_data_reg <= sel_data;
                last_q_reg  <= sel_last;
            end
`ifdef UART_TX_SCHED_ID_HDR_EN
            else if (go_hdr) begin
                tx_data_reg <= DATA_WIDTH'(onehot_to_idx(grant_next_pad));
            end
`endif
        end
    end

`ifdef UART_TX_SCHED_ID_HDR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       in_hdr_reg <= 1'b0;
        else if (go_hdr)  in_hdr_reg <= 1'b1;
        else if (go_send) in_hdr_reg <= 1'b0;
    end
`endif

    assign grant      = grant_reg;
    assign req_ack    = req_ack_reg;
    assign tx_data    = tx_data_reg;
    assign tx_valid   = tx_valid_reg;
    assign sched_busy = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a behavioural UART TX (busy 2 edges after valid, 20-cycle frame).
// Header-frame expectations switch on UART_TX_SCHED_ID_HDR_EN.
module tb_uart_tx_sched;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;
`ifdef UART_TX_SCHED_ID_HDR_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] req;
    logic [N*W-1:0] req_data;
    logic [N-1:0] req_last;
    logic [N-1:0] req_ack;
    logic [N-1:0] grant;
    logic [W-1:0] tx_data;
    logic         tx_valid;
    logic         tx_busy;
    logic         sched_busy;

    always #5 clk = ~clk;

    uart_tx_sched #(.N_REQ(N), .DATA_WIDTH(W), .MAX_BURST(MB)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ack    (req_ack),
        .grant      (grant),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_busy    (tx_busy),
        .sched_busy (sched_busy)
    );

    // Behavioural UART TX
    logic pend;
    int   bit_cnt;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_busy <= 1'b0;
            pend    <= 1'b0;
            bit_cnt <= 0;
        end else begin
            pend <= tx_valid;
            if (pend) begin
                tx_busy <= 1'b1;
                bit_cnt <= 19;
            end else if (tx_busy) begin
                if (bit_cnt == 0) tx_busy <= 1'b0;
                else              bit_cnt <= bit_cnt - 1;
            end
        end
    end

    // Requester sources: bit 8 = last flag
    logic [8:0] src_q [N][$];
    bit         inf_en [N];
    logic [7:0] inf_val [N];

    logic [7:0] frame_log [$];
    logic [7:0] data_log [$];
    logic [3:0] grant_log [$];
    int         ack_cnt [N];
    int         viol_busy, viol_consec, viol_stable, viol_ack;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic update_inputs();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                req[i] = 1'b1;
                req_data[i*W +: W] = src_q[i][0][7:0];
                req_last[i] = src_q[i][0][8];
            end else if (inf_en[i]) begin
                req[i] = 1'b1;
                req_data[i*W +: W] = inf_val[i];
                req_last[i] = 1'b0;
            end else begin
                req[i] = 1'b0;
                req_data[i*W +: W] = '0;
                req_last[i] = 1'b0;
            end
        end
    endtask

    task automatic clear_logs();
        frame_log.delete();
        data_log.delete();
        grant_log.delete();
        for (int i = 0; i < N; i++) ack_cnt[i] = 0;
    endtask

    function automatic logic [31:0] data_at(int k);
        return (k < data_log.size()) ? 32'(data_log[k]) : 32'hDEAD;
    endfunction

    function automatic logic [31:0] grant_at(int k);
        return (k < grant_log.size()) ? 32'(grant_log[k]) : 32'hDEAD;
    endfunction

    function automatic logic [31:0] frame_at(int k);
        return (k < frame_log.size()) ? 32'(frame_log[k]) : 32'hDEAD;
    endfunction

    // Monitor + requester driver, sampled on the falling edge
    logic       prev_valid = 1'b0;
    logic [3:0] prev_grant = '0;
    logic [7:0] frame_data = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_valid = 1'b0;
                prev_grant = '0;
            end else begin
                if (tx_valid) begin
                    if (tx_busy)    viol_busy++;
                    if (prev_valid) viol_consec++;
                    frame_data = tx_data;
                    frame_log.push_back(tx_data);
                    if (req_ack != '0) data_log.push_back(tx_data);
                    $display("tx frame=0x%02h ack=%b grant=%b t=%0t", tx_data, req_ack, grant, $time);
                end
                if (req_ack != '0 && !tx_valid) viol_ack++;
                if (tx_busy && tx_data !== frame_data) viol_stable++;
                if (grant != '0 && grant != prev_grant) grant_log.push_back(grant);
                prev_valid = tx_valid;
                prev_grant = grant;
                for (int i = 0; i < N; i++) begin
                    if (req_ack[i]) begin
                        ack_cnt[i]++;
                        if (src_q[i].size() > 0) void'(src_q[i].pop_front());
                        else if (inf_en[i])     inf_val[i] = inf_val[i] + 8'd1;
                    end
                end
                update_inputs();
            end
        end
    end

    task automatic wait_idle(input string tag);
        int cyc;
        cyc = 0;
        @(negedge clk);
        while (!(sched_busy == 1'b0 && req == '0) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done"}, 32'(cyc < 3000), 32'd1);
    endtask

    initial begin
        int cyc;
        req = '0; req_data = '0; req_last = '0;
        viol_busy = 0; viol_consec = 0; viol_stable = 0; viol_ack = 0;
        for (int i = 0; i < N; i++) begin
            inf_en[i] = 1'b0;
            inf_val[i] = '0;
        end
        clear_logs();

        repeat (3) @(negedge clk);
        check("rst_grant",    32'(grant), 32'h0);
        check("rst_ack",      32'(req_ack), 32'h0);
        check("rst_valid",    32'(tx_valid), 32'h0);
        check("rst_data",     32'(tx_data), 32'h0);
        check("rst_busy",     32'(sched_busy), 32'h0);
        check("rst_rr_ptr",   32'(dut.rr_ptr_reg), 32'h0);
        reset = 1'b1;

        // T1: single requester, three bytes
        @(negedge clk);
        clear_logs();
        src_q[0].push_back({1'b0, 8'hA5});
        src_q[0].push_back({1'b0, 8'h3C});
        src_q[0].push_back({1'b1, 8'h81});
        update_inputs();
        @(posedge clk); #1;
        check("t1_lat_grant", 32'(grant), 32'h1);
        check("t1_lat_valid", 32'(tx_valid), 32'h1);
        check("t1_lat_ack",   32'(req_ack), HDR_EN ? 32'h0 : 32'h1);
        check("t1_lat_data",  32'(tx_data), HDR_EN ? 32'h00 : 32'hA5);
        wait_idle("t1");
        check("t1_n_bytes", 32'(data_log.size()), 32'd3);
        check("t1_byte0",   data_at(0), 32'hA5);
        check("t1_byte1",   data_at(1), 32'h3C);
        check("t1_byte2",   data_at(2), 32'h81);
        check("t1_acks0",   32'(ack_cnt[0]), 32'd3);
        check("t1_grant",   32'(grant), 32'h0);
        check("t1_rr_ptr",  32'(dut.rr_ptr_reg), 32'h1);

        // T2: req0 and req2 with rr_ptr=1 -> 2 wins first
        @(negedge clk);
        clear_logs();
        src_q[0].push_back({1'b1, 8'h11});
        src_q[2].push_back({1'b1, 8'h22});
        update_inputs();
        wait_idle("t2");
        check("t2_grant_first",  grant_at(0), 32'h4);
        check("t2_grant_second", grant_at(1), 32'h1);
        check("t2_byte0",        data_at(0), 32'h22);
        check("t2_byte1",        data_at(1), 32'h11);
        check("t2_rr_ptr",       32'(dut.rr_ptr_reg), 32'h1);

        // T3: req1 streams forever, burst cap forces rotation to req3
        @(negedge clk);
        clear_logs();
        inf_en[1] = 1'b1;
        inf_val[1] = 8'h40;
        src_q[3].push_back({1'b1, 8'h33});
        update_inputs();
        cyc = 0;
        while (grant != 4'b1000 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("t3_grant3_seen", 32'(cyc < 3000), 32'd1);
        check("t3_acks1_burst", 32'(ack_cnt[1]), 32'd4);
        inf_en[1] = 1'b0;
        update_inputs();
        wait_idle("t3");
        check("t3_acks3",   32'(ack_cnt[3]), 32'd1);
        check("t3_grant_a", grant_at(0), 32'h2);
        check("t3_grant_b", grant_at(1), 32'h8);
        check("t3_byte3",   data_at(3), 32'h43);
        check("t3_byte4",   data_at(4), 32'h33);

        // T4: reset while waiting for busy to fall
        @(negedge clk);
        clear_logs();
        src_q[1].push_back({1'b0, 8'hB1});
        src_q[1].push_back({1'b0, 8'hB2});
        src_q[1].push_back({1'b1, 8'hB3});
        update_inputs();
        cyc = 0;
        while (!tx_busy && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("t4_busy_seen", 32'(cyc < 200), 32'd1);
        repeat (3) @(negedge clk);
        check("t4_pre_grant", 32'(grant), 32'h2);
        #2 reset = 1'b0;
        #1;
        check("t4_grant", 32'(grant), 32'h0);
        check("t4_ack",   32'(req_ack), 32'h0);
        check("t4_valid", 32'(tx_valid), 32'h0);
        check("t4_data",  32'(tx_data), 32'h0);
        check("t4_busy",  32'(sched_busy), 32'h0);
        check("t4_rr_ptr", 32'(dut.rr_ptr_reg), 32'h0);
        src_q[1].delete();
        clear_logs();
        src_q[2].push_back({1'b1, 8'h77});
        src_q[3].push_back({1'b1, 8'h66});
        update_inputs();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("t4_regrant", 32'(grant), 32'h4);
        wait_idle("t4");
        check("t4_byte0", data_at(0), 32'h77);
        check("t4_byte1", data_at(1), 32'h66);

`ifdef UART_TX_SCHED_ID_HDR_EN
        // T5: header frame carries requester index, ack only on data frame
        @(negedge clk);
        clear_logs();
        src_q[3].push_back({1'b1, 8'h55});
        update_inputs();
        wait_idle("t5");
        check("t5_n_frames", 32'(frame_log.size()), 32'd2);
        check("t5_hdr",      frame_at(0), 32'h03);
        check("t5_data",     frame_at(1), 32'h55);
        check("t5_n_data",   32'(data_log.size()), 32'd1);
        check("t5_acks3",    32'(ack_cnt[3]), 32'd1);
`endif

        check("valid_while_busy", 32'(viol_busy), 32'd0);
        check("valid_back2back",  32'(viol_consec), 32'd0);
        check("data_stable",      32'(viol_stable), 32'd0);
        check("ack_with_valid",   32'(viol_ack), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one UART transmitter among `N_REQ` byte-stream requesters. It arbitrates between the requesters and grants one at a time for a burst of bytes. It presents each byte to the transmitter with a single-cycle valid pulse, then tracks the transmitter's `busy` flag to pace the frames. It sits between the system-side byte producers and the UART TX `Data_Valid`/`P_DATA`/`busy` interface.

## Interface
- `N_REQ`, 4, number of requesters (2..16)
- `DATA_WIDTH`, 8, byte width; matches UART TX frame width
- `MAX_BURST`, 16, max data bytes per grant before forced rotation (≥1)
- clk, reset: reset asynchronous, active-low; clock clk.
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous active-low reset
- `req`  in  N_REQ  per-requester "byte available"
- `req_data`  in  N_REQ*DATA_WIDTH  packed bytes; requester i at `[i*DATA_WIDTH +: DATA_WIDTH]`
- `req_last`  in  N_REQ  current byte is last of the requester's message
- `req_ack`  out  N_REQ  one-cycle pulse: byte of requester i consumed
- `grant`  out  N_REQ  one-hot current owner; 0 when idle
- `tx_data`  out  DATA_WIDTH  byte to UART TX (`P_DATA`)
- `tx_valid`  out  1  one-cycle pulse to UART TX (`Data_Valid`)
- `tx_busy`  in  1  UART TX `busy` (registered in the TX)
- `sched_busy`  out  1  high in any state except IDLE

## Operation
- States: IDLE, HDR (only when configured), SEND, WAIT_HI, WAIT_LO.
- IDLE: if any `req` is set, the winner is the first set bit searching upward from `rr_ptr`, wrapping. Register a one-hot `grant`, clear `burst_cnt`, then go to HDR if configured, otherwise SEND.
- SEND:
  - Latch `req_data[g]` into `tx_data`, assert `tx_valid`, and pulse `req_ack[g]`.
  - Latch `req_last[g]` into `last_q` and increment `burst_cnt`.
  - Go to WAIT_HI.
- WAIT_HI: wait for `tx_busy`=1, then go to WAIT_LO.
- WAIT_LO: wait for `tx_busy`=0. Then:
  - If `last_q`, or `burst_cnt`==MAX_BURST, or `req[g]`=0: release the grant, set `rr_ptr`=(g+1) mod N_REQ, and go to IDLE.
  - Otherwise go to SEND.
- `tx_data` holds its value from SEND until the next SEND or HDR; it never changes while a frame is in flight.
- `req` dropping during WAIT_* does not abort the frame; the burst ends after that frame.
- `req_data` and `req_last` are sampled only in the SEND cycle.
- `rr_ptr` advances only on release. A requester that holds `req` high therefore gets at most MAX_BURST bytes before the others are considered.
- `burst_cnt` width is $clog2(MAX_BURST+1).
- No timeout: if `tx_busy` never rises, the block stays in WAIT_HI until reset.

## Timing
- Reset values: `grant`=0, `req_ack`=0, `tx_valid`=0, `tx_data`=0, `sched_busy`=0, `rr_ptr`=0, state IDLE.
- Reset is effective immediately at any point, including mid-frame.
- Latency: `req` sampled at edge n in IDLE gives `grant` valid after edge n. `tx_valid` and `req_ack` are high for exactly the cycle following edge n; with HDR, that pulse is the header and the data byte follows one frame later.
- The UART TX raises `busy` 2 edges after `tx_valid`; WAIT_HI lasts ≥1 cycle.
- After the `tx_busy` fall is sampled, the next `tx_valid` comes 1 cycle later, in the cycle where the TX is back in IDLE.
- Release-to-new-grant: one IDLE cycle.
- `tx_valid` is never asserted while `tx_busy`=1 or in two consecutive cycles.

## Configuration
- `UART_TX_SCHED_ID_HDR_EN` defined: each grant starts with an HDR frame.
  - `tx_data` = requester index, zero-extended to DATA_WIDTH.
  - The HDR frame uses the same `tx_valid`/WAIT_HI/WAIT_LO sequence and then goes to SEND, not IDLE.
  - HDR produces no `req_ack` and does not count toward `burst_cnt`.
- Macro undefined: the HDR state and its logic are absent, and IDLE goes directly to SEND.

## Structure
- Package `uart_tx_sched_pkg`: state enum `sched_state_e`, `HDR_ID` width constant, and a function that computes one-hot to index.
- Sub-module `uart_rr_arbiter`: combinational; inputs `req` and `rr_ptr`; outputs one-hot `winner` and `any`. Parameterized by N_REQ.
- The FSM, `burst_cnt`, `last_q`, and the output registers stay in `uart_tx_sched`.

## Test plan
- Single requester, 3 bytes 0xA5, 0x3C, 0x81, with `req_last` on the third byte: 3 `tx_valid` pulses carrying those values, 3 `req_ack[0]` pulses, then `grant`→0 and `rr_ptr`=1.
- req[0] and req[2] both high in IDLE with rr_ptr=1: `grant[2]` is first. After its burst ends, `grant[0]` is next.
- req[1] held high with unbounded data, MAX_BURST=4, req[3] also pending: exactly 4 acks to requester 1, then `grant[3]`.
- Behavioural UART TX model (busy rises 2 edges after valid, frame 10 bits): no `tx_valid` while busy high; `tx_data` is stable for the whole frame.
- Reset asserted during WAIT_LO: all outputs 0 immediately. After release with `req[2]` set, `grant[2]` appears from `rr_ptr`=0.
- With `UART_TX_SCHED_ID_HDR_EN` and requester 3 sending 0x55: frames 0x03 then 0x55, with one `req_ack[3]`, only on the 0x55 frame.
